ddr_read_arbiter: RTL and testbench

Shares the single DDR read engine (address/length command port plus its read-data FIFO) between `NUM_CLIENTS` buffer loaders: the bias, weight and feature FIFO controllers. Each loader issues its normal one-cycle configuration (start address, byte length). The arbiter queues these requests, grants them round-robin, and forwards the winning command to the DDR engine. It then routes the engine's FIFO to the granted loader until that request's beat count is exhausted. Loaders need no change; each sees a private DDR command/FIFO port.

---
 rtl/ddr_read_arbiter_if.sv | 48 ++++
 rtl/ddr_read_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_ddr_read_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_read_arbiter_if.sv
// Client-side and DDR-engine-side signals shared by the read arbiter and its environment.
interface ddr_read_arbiter_if #(
  parameter int unsigned NUM_CLIENTS  = 3,
  parameter int unsigned DDR_ADDR_LEN = 32,
  parameter int unsigned SINGLE_LEN   = 24,
  parameter int unsigned DATA_LEN     = 64
);

  // Loader-facing command and FIFO ports
  logic [NUM_CLIENTS-1:0]              cli_conf;
  logic [NUM_CLIENTS*DDR_ADDR_LEN-1:0] cli_addr;
  logic [NUM_CLIENTS*SINGLE_LEN-1:0]   cli_len;
  logic [NUM_CLIENTS-1:0]              cli_fifo_empty;
  logic [NUM_CLIENTS-1:0]              cli_fifo_req;
  logic [DATA_LEN-1:0]                 cli_fifo_data;
  logic [NUM_CLIENTS-1:0]              cli_err;

  // DDR read engine command and FIFO ports
  logic                                ddr_conf;
  logic [DDR_ADDR_LEN-1:0]             ddr_st_addr;
  logic [SINGLE_LEN-1:0]               ddr_len;
  logic                                ddr_fifo_empty;
  logic                                ddr_fifo_req;
  logic [DATA_LEN-1:0]                 ddr_fifo_data;

  // Status
  logic [NUM_CLIENTS-1:0]              grant;
  logic                                idle;

  // Arbiter view
  modport slave (
    input  cli_conf, cli_addr, cli_len, cli_fifo_req,
    input  ddr_fifo_empty, ddr_fifo_data,
    output cli_fifo_empty, cli_fifo_data, cli_err,
    output ddr_conf, ddr_st_addr, ddr_len, ddr_fifo_req,
    output grant, idle
  );

  // Loaders plus DDR engine view
  modport master (
    output cli_conf, cli_addr, cli_len, cli_fifo_req,
    output ddr_fifo_empty, ddr_fifo_data,
    input  cli_fifo_empty, cli_fifo_data, cli_err,
    input  ddr_conf, ddr_st_addr, ddr_len, ddr_fifo_req,
    input  grant, idle
  );

endinterface

// File: rtl/ddr_read_arbiter.sv
// Round-robin sharing of one DDR read engine (command port + read FIFO) among
// several buffer loaders; each loader keeps a private-looking command/FIFO port.
module ddr_read_arbiter #(
  parameter int unsigned NUM_CLIENTS  = 3,
  parameter int unsigned DDR_ADDR_LEN = 32,
  parameter int unsigned SINGLE_LEN   = 24,
  parameter int unsigned DATA_LEN     = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  ddr_read_arbiter_if.slave  bus
);

  localparam int unsigned IDX_W          = $clog2(NUM_CLIENTS);
  localparam int unsigned BYTES_PER_BEAT = DATA_LEN / 8;
  localparam int unsigned BEAT_SHIFT     = $clog2(BYTES_PER_BEAT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_STREAM = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        last_q, last_d;
  logic [NUM_CLIENTS-1:0]  pend_q, pend_d;
  logic [NUM_CLIENTS-1:0]  grant_q, grant_d;
  logic [NUM_CLIENTS-1:0]  err_q, err_d;
  logic [DDR_ADDR_LEN-1:0] addr_q [NUM_CLIENTS];
  logic [DDR_ADDR_LEN-1:0] addr_d [NUM_CLIENTS];
  logic [SINGLE_LEN-1:0]   len_q  [NUM_CLIENTS];
  logic [SINGLE_LEN-1:0]   len_d  [NUM_CLIENTS];
  logic [SINGLE_LEN-1:0]   beats_q, beats_d;
  logic                    ddr_conf_q, ddr_conf_d;
  logic [DDR_ADDR_LEN-1:0] ddr_addr_q, ddr_addr_d;
  logic [SINGLE_LEN-1:0]   ddr_len_q, ddr_len_d;

  logic [NUM_CLIENTS-1:0]  accept;
  logic [NUM_CLIENTS-1:0]  empty_c;
  logic                    pop;
  logic                    pick_valid;
  logic [IDX_W-1:0]        pick_idx;
  logic [IDX_W-1:0]        cand;
  logic [SINGLE_LEN-1:0]   pick_beats;

  // Beat count of a byte length, rounded up, without overflow near the top of the range.
  function automatic logic [SINGLE_LEN-1:0] beats_of(input logic [SINGLE_LEN-1:0] len);
    logic [SINGLE_LEN-1:0] rem;
    rem = len & SINGLE_LEN'(BYTES_PER_BEAT - 1);
    return (len >> BEAT_SHIFT) + SINGLE_LEN'(rem != '0);
  endfunction

  // A client slot takes a new command only when it is neither waiting nor being served.
  assign accept = bus.cli_conf & ~pend_q & ~grant_q;

  // Round-robin pick: first pending client scanning upward from the one after the last winner.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned k = 1; k <= NUM_CLIENTS; k++) begin
      cand = IDX_W'((32'(last_q) + k) % NUM_CLIENTS);
      if (!pick_valid && pend_q[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign pick_beats = beats_of(len_q[pick_idx]);

  // Only the owner sees the engine FIFO, and only while it still has beats left to take.
  always_comb begin
    empty_c = '1;
    if (state_q == S_STREAM) begin
      empty_c[last_q] = bus.ddr_fifo_empty | (beats_q == '0);
    end
  end

  assign pop = (state_q == S_STREAM) & bus.cli_fifo_req[last_q] & ~empty_c[last_q];

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: IDLE -> ISSUE -> STREAM -> IDLE, skipping STREAM for zero-length requests.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (pick_valid) state_d = S_ISSUE;
      S_ISSUE:  state_d = (beats_q == '0) ? S_IDLE : S_STREAM;
      S_STREAM: if (pop && (beats_q == SINGLE_LEN'(1))) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output/datapath next values: slot capture, grant, command and beat countdown.
  always_comb begin
    pend_d     = pend_q | accept;
    err_d      = err_q | (bus.cli_conf & ~accept);
    addr_d     = addr_q;
    len_d      = len_q;
    last_d     = last_q;
    grant_d    = grant_q;
    beats_d    = beats_q;
    ddr_conf_d = 1'b0;
    ddr_addr_d = ddr_addr_q;
    ddr_len_d  = ddr_len_q;

    for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
      if (accept[i]) begin
        addr_d[i] = bus.cli_addr[i*DDR_ADDR_LEN +: DDR_ADDR_LEN];
        len_d[i]  = bus.cli_len[i*SINGLE_LEN +: SINGLE_LEN];
      end
    end

    case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          pend_d[pick_idx] = 1'b0;
          grant_d          = NUM_CLIENTS'(1) << pick_idx;
          last_d           = pick_idx;
          beats_d          = pick_beats;
          if (pick_beats != '0) begin
            ddr_conf_d = 1'b1;
            ddr_addr_d = addr_q[pick_idx];
            ddr_len_d  = len_q[pick_idx];
          end
        end
      end
      S_ISSUE: begin
        if (beats_q == '0) grant_d = '0;
      end
      S_STREAM: begin
        if (pop) begin
          beats_d = beats_q - SINGLE_LEN'(1);
          if (beats_q == SINGLE_LEN'(1)) grant_d = '0;
        end
      end
      default: ;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q     <= IDX_W'(NUM_CLIENTS - 1);
      pend_q     <= '0;
      grant_q    <= '0;
      err_q      <= '0;
      beats_q    <= '0;
      ddr_conf_q <= 1'b0;
      ddr_addr_q <= '0;
      ddr_len_q  <= '0;
      for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
        addr_q[i] <= '0;
        len_q[i]  <= '0;
      end
    end else begin
      last_q     <= last_d;
      pend_q     <= pend_d;
      grant_q    <= grant_d;
      err_q      <= err_d;
      beats_q    <= beats_d;
      ddr_conf_q <= ddr_conf_d;
      ddr_addr_q <= ddr_addr_d;
      ddr_len_q  <= ddr_len_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
    end
  end

  assign bus.cli_fifo_empty = empty_c;
  assign bus.cli_fifo_data  = bus.ddr_fifo_data;
  assign bus.cli_err        = err_q;
  assign bus.ddr_conf       = ddr_conf_q;
  assign bus.ddr_st_addr    = ddr_addr_q;
  assign bus.ddr_len        = ddr_len_q;
  assign bus.ddr_fifo_req   = pop;
  assign bus.grant          = grant_q;
  assign bus.idle           = (state_q == S_IDLE) & ~|pend_q;

endmodule

// File: tb/tb_ddr_read_arbiter.sv
// Bench for ddr_read_arbiter: vector table, hand-written corner sequences, and a
// grant/command/pop scoreboard fed from the stimulus side.
module tb_ddr_read_arbiter;

  localparam int unsigned NC = 3;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  ddr_read_arbiter_if bus ();

  ddr_read_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int          client;
    logic [31:0] addr;
    logic [23:0] len;
    int          beats;
  } req_t;

  req_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   rand_mode = 1'b0;

  // monitor state
  logic [NC-1:0] prev_grant;
  bit            active;
  req_t          cur;
  int            pops;
  int            last_pops = -1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  // Scoreboard: each new grant takes the next expected request; its pop count is checked at release.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_grant = '0;
      active     = 1'b0;
      pops       = 0;
    end else begin
      chk("fifo_data", bus.cli_fifo_data, bus.ddr_fifo_data);
      if (bus.grant == '0) begin
        chk("empty_when_free", 64'(bus.cli_fifo_empty), 64'(3'b111));
      end else begin
        for (int i = 0; i < int'(NC); i++) begin
          if (!bus.grant[i]) chk("empty_not_owner", 64'(bus.cli_fifo_empty[i]), 64'(1));
        end
      end

      if (bus.grant == '0 && prev_grant != '0 && active) begin
        chk("beat_count", 64'(pops), 64'(cur.beats));
        last_pops = pops;
        active    = 1'b0;
      end

      if (bus.grant != '0 && prev_grant == '0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_grant", 64'(bus.grant), 64'(0));
        end else begin
          cur    = exp_q.pop_front();
          active = 1'b1;
          pops   = 0;
          chk("grant_owner", 64'(bus.grant), 64'(3'b001 << cur.client));
          chk("conf_issued", 64'(bus.ddr_conf), 64'(cur.beats != 0));
          if (cur.beats != 0) begin
            chk("cmd_addr", 64'(bus.ddr_st_addr), 64'(cur.addr));
            chk("cmd_len", 64'(bus.ddr_len), 64'(cur.len));
          end
        end
      end else begin
        chk("no_stray_conf", 64'(bus.ddr_conf), 64'(0));
        if (bus.grant != '0 && bus.grant != prev_grant)
          chk("grant_switch", 64'(bus.grant), 64'(prev_grant));
      end

      if (bus.ddr_fifo_req) begin
        pops++;
        chk("pop_not_empty", 64'(bus.ddr_fifo_empty), 64'(0));
        chk("pop_owned", 64'(bus.grant != '0), 64'(1));
      end
      prev_grant = bus.grant;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
    bus.cli_conf = '0;
    if (rand_mode) begin
      bus.cli_fifo_req   = 3'($urandom);
      bus.ddr_fifo_empty = ($urandom_range(0, 3) == 0);
    end else begin
      bus.cli_fifo_req   = '1;
      bus.ddr_fifo_empty = 1'b0;
    end
    bus.ddr_fifo_data = {$urandom, $urandom};
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic set_cmd(input int c, input logic [31:0] a, input logic [23:0] l);
    bus.cli_conf[c]         = 1'b1;
    bus.cli_addr[c*32 +: 32] = a;
    bus.cli_len[c*24 +: 24]  = l;
  endtask

  task automatic expect_req(input int c, input logic [31:0] a, input logic [23:0] l);
    req_t r;
    r.client = c;
    r.addr   = a;
    r.len    = l;
    r.beats  = (int'(l) + 7) / 8;
    exp_q.push_back(r);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    do begin
      next_cycle();
      n++;
    end while (!bus.idle && n < 3000);
    chk({name, "_idle"}, 64'(bus.idle), 64'(1));
    sample();
  endtask

  task automatic do_reset();
    bus.cli_conf = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    chk("rst_ddr_conf", 64'(bus.ddr_conf), 64'(0));
    chk("rst_ddr_addr", 64'(bus.ddr_st_addr), 64'(0));
    chk("rst_ddr_len", 64'(bus.ddr_len), 64'(0));
    chk("rst_grant", 64'(bus.grant), 64'(0));
    chk("rst_err", 64'(bus.cli_err), 64'(0));
    chk("rst_cli_empty", 64'(bus.cli_fifo_empty), 64'(3'b111));
    chk("rst_fifo_req", 64'(bus.ddr_fifo_req), 64'(0));
    chk("rst_idle", 64'(bus.idle), 64'(1));
    rst_n = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req_t vecs[6];
    int   n;

    vecs[0] = '{0, 32'h0000_2000, 24'd20,  3};
    vecs[1] = '{1, 32'h0000_3008, 24'd8,   1};
    vecs[2] = '{2, 32'h0000_3100, 24'd1,   1};
    vecs[3] = '{0, 32'h0000_3200, 24'd9,   2};
    vecs[4] = '{1, 32'h0000_3300, 24'd0,   0};
    vecs[5] = '{2, 32'h0000_3400, 24'd200, 25};

    rst_n              = 1'b0;
    bus.cli_conf       = '0;
    bus.cli_addr       = '0;
    bus.cli_len        = '0;
    bus.cli_fifo_req   = '0;
    bus.ddr_fifo_empty = 1'b1;
    bus.ddr_fifo_data  = '0;

    do_reset();

    // Single request, fixed latency, exactly 8 pops with an always-ready engine.
    rand_mode = 1'b0;
    next_cycle();
    set_cmd(0, 32'h0000_1000, 24'd64);
    expect_req(0, 32'h0000_1000, 24'd64);
    next_cycle();
    sample();
    chk("lat_t1_grant", 64'(bus.grant), 64'(0));
    chk("lat_t1_idle", 64'(bus.idle), 64'(0));
    next_cycle();
    sample();
    chk("lat_t2_grant", 64'(bus.grant), 64'(3'b001));
    chk("lat_t2_conf", 64'(bus.ddr_conf), 64'(1));
    chk("lat_t2_addr", 64'(bus.ddr_st_addr), 64'(32'h1000));
    chk("lat_t2_len", 64'(bus.ddr_len), 64'(64));
    for (int k = 0; k < 8; k++) begin
      next_cycle();
      sample();
      chk("stream_grant", 64'(bus.grant), 64'(3'b001));
      chk("stream_pop", 64'(bus.ddr_fifo_req), 64'(1));
    end
    next_cycle();
    sample();
    chk("done_grant", 64'(bus.grant), 64'(0));
    chk("done_pop", 64'(bus.ddr_fifo_req), 64'(0));
    chk("done_pops", 64'(last_pops), 64'(8));
    next_cycle();
    sample();
    chk("done_idle", 64'(bus.idle), 64'(1));

    // Vector table: isolated requests with a randomly stalling engine and random pops.
    rand_mode = 1'b1;
    for (int v = 0; v < 6; v++) begin
      set_cmd(vecs[v].client, vecs[v].addr, vecs[v].len);
      expect_req(vecs[v].client, vecs[v].addr, vecs[v].len);
      wait_done("vec");
      chk("vec_beats", 64'(last_pops), 64'(vecs[v].beats));
      chk("vec_err", 64'(bus.cli_err), 64'(0));
    end

    // Round-robin from reset; client 0 re-requests while client 2 streams.
    do_reset();
    set_cmd(0, 32'h0000_4000, 24'd16);
    set_cmd(1, 32'h0000_5000, 24'd24);
    set_cmd(2, 32'h0000_6000, 24'd32);
    expect_req(0, 32'h0000_4000, 24'd16);
    expect_req(1, 32'h0000_5000, 24'd24);
    expect_req(2, 32'h0000_6000, 24'd32);
    n = 0;
    do begin
      next_cycle();
      n++;
    end while (bus.grant != 3'b100 && n < 500);
    chk("rr_reach_c2", 64'(bus.grant), 64'(3'b100));
    set_cmd(0, 32'h0000_7000, 24'd40);
    expect_req(0, 32'h0000_7000, 24'd40);
    wait_done("rr");
    chk("rr_drained", 64'(exp_q.size()), 64'(0));

    // Zero length: one-cycle grant pulse, then the next client after a single idle cycle.
    set_cmd(1, 32'h0000_8000, 24'd0);
    set_cmd(2, 32'h0000_9000, 24'd16);
    expect_req(1, 32'h0000_8000, 24'd0);
    expect_req(2, 32'h0000_9000, 24'd16);
    next_cycle();
    sample();
    chk("zl_t1_grant", 64'(bus.grant), 64'(0));
    next_cycle();
    sample();
    chk("zl_t2_grant", 64'(bus.grant), 64'(3'b010));
    chk("zl_t2_conf", 64'(bus.ddr_conf), 64'(0));
    next_cycle();
    sample();
    chk("zl_t3_grant", 64'(bus.grant), 64'(0));
    next_cycle();
    sample();
    chk("zl_t4_grant", 64'(bus.grant), 64'(3'b100));
    chk("zl_t4_conf", 64'(bus.ddr_conf), 64'(1));
    wait_done("zl");

    // Conflicts: commands to a pending and to a granted slot are dropped and flagged.
    set_cmd(1, 32'h0000_A000, 24'd80);
    expect_req(1, 32'h0000_A000, 24'd80);
    next_cycle();
    set_cmd(1, 32'h0000_BAD0, 24'd8);
    next_cycle();
    sample();
    chk("cf_err_pending", 64'(bus.cli_err), 64'(3'b010));
    chk("cf_grant", 64'(bus.grant), 64'(3'b010));
    next_cycle();
    next_cycle();
    set_cmd(1, 32'h0000_BAD1, 24'd8);
    wait_done("cf");
    chk("cf_err_final", 64'(bus.cli_err), 64'(3'b010));
    chk("cf_drained", 64'(exp_q.size()), 64'(0));

    // Reset mid-stream with two pending; afterwards client 0 wins first again.
    set_cmd(0, 32'h0000_C000, 24'd400);
    expect_req(0, 32'h0000_C000, 24'd400);
    n = 0;
    do begin
      next_cycle();
      n++;
    end while (bus.grant != 3'b001 && n < 500);
    chk("mr_granted", 64'(bus.grant), 64'(3'b001));
    next_cycle();
    set_cmd(1, 32'h0000_C100, 24'd16);
    set_cmd(2, 32'h0000_C200, 24'd16);
    next_cycle();
    next_cycle();
    sample();
    chk("mr_pending_idle", 64'(bus.idle), 64'(0));
    chk("mr_still_c0", 64'(bus.grant), 64'(3'b001));
    do_reset();
    set_cmd(0, 32'h0000_D000, 24'd24);
    set_cmd(1, 32'h0000_E000, 24'd8);
    expect_req(0, 32'h0000_D000, 24'd24);
    expect_req(1, 32'h0000_E000, 24'd8);
    wait_done("mr");
    chk("mr_drained", 64'(exp_q.size()), 64'(0));
    chk("mr_err", 64'(bus.cli_err), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
